tdf_loc_controller: RTL

//  Launch-on-capture (LOC) transition-delay test controller for a scan-inserted

---
 rtl/tdf_loc_controller.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/tdf_loc_controller.sv
// rtl/tdf_loc_controller.sv - launch-on-capture transition-delay test controller
// LFSR-driven scan/PI stimulus with MISR compaction of scan-out and POs.
module tdf_loc_controller #(
  parameter int          CHAIN_LEN = 8,
  parameter int          PI_W      = 11,
  parameter int          PO_W      = 2,
  parameter int          NPAT      = 64,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            START,
  input  logic            STOP,
  input  logic            SO,
  input  logic [PO_W-1:0] PO,
  output logic            SE,
  output logic            SI,
  output logic            CUT_CE,
  output logic [PI_W-1:0] PI,
  output logic            BUSY,
  output logic            DONE,
  output logic [15:0]     SIGNATURE
);

  localparam int          BW     = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);
  localparam logic [15:0] NPAT_L = 16'(NPAT);

  typedef enum logic [2:0] {IDLE, SHIFT, LAUNCH, CAPTURE, FLUSH} state_t;

  state_t          state, state_d;
  logic [15:0]     lfsr, lfsr_d, misr, misr_d, pat_cnt, pat_d, sig_d, po_ext;
  logic [BW-1:0]   bit_cnt, bit_d;
  logic [PI_W-1:0] pi_d;
  logic            done_d, si_d, se_d, ce_d;

  function automatic logic [15:0] step16(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always_comb begin
    po_ext = '0;
    po_ext[PO_W-1:0] = PO;
  end

  always_comb begin
    state_d = state;
    lfsr_d  = lfsr;
    misr_d  = misr;
    pat_d   = pat_cnt;
    bit_d   = bit_cnt;
    pi_d    = PI;
    sig_d   = SIGNATURE;
    done_d  = 1'b0;
    if (STOP) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            if (NPAT_L == 16'd0) begin
              done_d = 1'b1;
              sig_d  = '0;
            end else begin
              state_d = SHIFT;
              lfsr_d  = SEED;
              misr_d  = '0;
              pat_d   = '0;
              bit_d   = '0;
            end
          end
        end
        SHIFT: begin
          lfsr_d = step16(lfsr);
          // Chain contents before the first pattern are unknown, so keep them out
          if (pat_cnt != 16'd0) misr_d = step16(misr) ^ {15'b0, SO};
          if (bit_cnt == LAST_BIT) begin
            bit_d   = '0;
            pi_d    = lfsr_d[PI_W-1:0];
            state_d = LAUNCH;
          end else begin
            bit_d = bit_cnt + 1'b1;
          end
        end
        LAUNCH: state_d = CAPTURE;
        CAPTURE: begin
          misr_d  = step16(misr) ^ po_ext;
          pat_d   = pat_cnt + 16'd1;
          state_d = (pat_d < NPAT_L) ? SHIFT : FLUSH;
        end
        FLUSH: begin
          misr_d = step16(misr) ^ {15'b0, SO};
          if (bit_cnt == LAST_BIT) begin
            bit_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
            sig_d   = misr_d;
          end else begin
            bit_d = bit_cnt + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Outputs are registered from the next state so they line up with it
    se_d = (state_d == SHIFT) || (state_d == FLUSH);
    ce_d = (state_d != IDLE);
    si_d = (state_d == SHIFT) ? lfsr_d[0] : 1'b0;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      lfsr      <= SEED;
      misr      <= '0;
      pat_cnt   <= '0;
      bit_cnt   <= '0;
      SE        <= 1'b0;
      SI        <= 1'b0;
      CUT_CE    <= 1'b0;
      PI        <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      SIGNATURE <= '0;
    end else begin
      state     <= state_d;
      lfsr      <= lfsr_d;
      misr      <= misr_d;
      pat_cnt   <= pat_d;
      bit_cnt   <= bit_d;
      SE        <= se_d;
      SI        <= si_d;
      CUT_CE    <= ce_d;
      PI        <= pi_d;
      BUSY      <= ce_d;
      DONE      <= done_d;
      SIGNATURE <= sig_d;
    end
  end

endmodule
